// File: rtl/time_scaler.sv
// Game-time base: divides clk into per-speed half-period ticks and a toggling time signal.
// Define TIME_SCALER_PAUSE_EN to build the pause button logic; otherwise paused is tied low.
module time_scaler #(
  parameter int          BASE_HALF  = 25000000,
  parameter int          NUM_SPEEDS = 6,
  parameter logic [63:0] FACTORS    = 64'({8'd100, 8'd50, 8'd10, 8'd5, 8'd2, 8'd1})
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_pause,
  output logic       tick,
  output logic       newtime,
  output logic [2:0] velocidad,
  output logic       paused
);

  localparam int         CW   = $clog2(BASE_HALF + 1);
  localparam logic [2:0] LAST = 3'(NUM_SPEEDS - 1);

  // Per-speed terminal counts are constants; unused slots read as zero.
  logic [CW-1:0] lim_arr [8];

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_lim
      if (gi < NUM_SPEEDS) begin : g_used
        assign lim_arr[gi] = CW'(BASE_HALF / int'(FACTORS[8*gi +: 8]));
      end else begin : g_unused
        assign lim_arr[gi] = '0;
      end
    end
  endgenerate

  logic [CW-1:0] count_q, count_d;
  logic          tick_q, tick_d;
  logic          newtime_q, newtime_d;
  logic [2:0]    vel_q, vel_d;
  logic          up_prev_q, dn_prev_q;
  logic          up_edge, dn_edge;
  logic          hold;

`ifdef TIME_SCALER_PAUSE_EN
  logic pause_prev_q;
  logic paused_q, paused_d;
  logic pause_edge;

  assign pause_edge = btn_pause & ~pause_prev_q;
  assign paused_d   = paused_q ^ pause_edge;
  assign hold       = paused_q;
  assign paused     = paused_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pause_prev_q <= 1'b0;
      paused_q     <= 1'b0;
    end else begin
      pause_prev_q <= btn_pause;
      paused_q     <= paused_d;
    end
  end
`else
  logic unused_btn_pause;

  assign unused_btn_pause = btn_pause;
  assign hold             = 1'b0;
  assign paused           = 1'b0;
`endif

  assign up_edge = btn_up & ~up_prev_q;
  assign dn_edge = btn_down & ~dn_prev_q;

  always_comb begin
    count_d   = count_q;
    tick_d    = 1'b0;
    newtime_d = newtime_q;
    vel_d     = vel_q;
    // Simultaneous up and down edges cancel and leave the counter alone.
    if (up_edge ^ dn_edge) begin
      if (up_edge) begin
        vel_d = (vel_q == LAST) ? 3'd0 : vel_q + 3'd1;
      end else begin
        vel_d = (vel_q == 3'd0) ? LAST : vel_q - 3'd1;
      end
      count_d = '0;
    end else if (hold) begin
      count_d = count_q;
    end else if (count_q == lim_arr[vel_q]) begin
      count_d   = '0;
      tick_d    = 1'b1;
      newtime_d = ~newtime_q;
    end else begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= '0;
      tick_q    <= 1'b0;
      newtime_q <= 1'b0;
      vel_q     <= 3'd0;
      up_prev_q <= 1'b0;
      dn_prev_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      tick_q    <= tick_d;
      newtime_q <= newtime_d;
      vel_q     <= vel_d;
      up_prev_q <= btn_up;
      dn_prev_q <= btn_down;
    end
  end

  assign tick      = tick_q;
  assign newtime   = newtime_q;
  assign velocidad = vel_q;

endmodule

// File: tb/tb_time_scaler.sv
// Directed bench for time_scaler with BASE_HALF=20, four speeds (limits 20, 10, 4, 2).
module tb_time_scaler;

  localparam int          BH = 20;
  localparam int          NS = 4;
  localparam logic [63:0] FS = 64'({8'd10, 8'd5, 8'd2, 8'd1});

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       btn_pause = 1'b0;
  logic       tick, newtime, paused;
  logic [2:0] velocidad;

  time_scaler #(.BASE_HALF(BH), .NUM_SPEEDS(NS), .FACTORS(FS)) dut (
    .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down), .btn_pause(btn_pause),
    .tick(tick), .newtime(newtime), .velocidad(velocidad), .paused(paused)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];
  int lim [4] = '{20, 10, 4, 2};

  task automatic push_exp(logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(string tag, logic [31:0] obs);
    logic [31:0] e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $error("FAIL %s scoreboard empty, observed=%0d", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        fails++;
        $error("FAIL %s observed=%0d expected=%0d", tag, obs, e);
      end
    end
  endtask

  task automatic cmp(string tag, logic [31:0] obs, logic [31:0] e);
    push_exp(e);
    check(tag, obs);
  endtask

  task automatic wait_tick(int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (tick === 1'b1) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic tick_gap(string tag, int ref_c, int gap, output int at);
    push_exp(32'(gap));
    wait_tick(gap + 5, at);
    check(tag, (at < 0) ? 32'hFFFF_FFFF : 32'(at - ref_c));
  endtask

  task automatic goto_cyc(int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive a one-cycle button pattern; ref_c is the edge that sampled it.
  task automatic pulse(bit u, bit d, bit p, output int ref_c);
    btn_up = u; btn_down = d; btn_pause = p;
    @(posedge clk);
    #1;
    btn_up = 1'b0; btn_down = 1'b0; btn_pause = 1'b0;
    ref_c = cyc;
  endtask

  task automatic count_ticks(int n, output int seen);
    seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (tick === 1'b1) seen++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t, r, seen;
    logic nt;

    repeat (3) @(posedge clk);
    #1;
    cmp("rst_tick", {31'b0, tick}, 0);
    cmp("rst_newtime", {31'b0, newtime}, 0);
    cmp("rst_vel", {29'b0, velocidad}, 0);
    cmp("rst_paused", {31'b0, paused}, 0);
    rst = 1'b0;
    r = cyc;
    tick_gap("base_first", r, 21, t);
    cmp("base_newtime1", {31'b0, newtime}, 1);
    tick_gap("base_period", t, 21, t);
    cmp("base_newtime0", {31'b0, newtime}, 0);
    $display("[TB] reset/base period done at cycle %0d", cyc);

    for (int k = 1; k <= 4; k++) begin
      pulse(1, 0, 0, r);
      cmp($sformatf("up_vel_%0d", k), {29'b0, velocidad}, 32'(k % 4));
      tick_gap($sformatf("up_first_%0d", k), r, lim[k % 4] + 1, t);
      tick_gap($sformatf("up_period_%0d", k), t, lim[k % 4] + 1, t);
      $display("[TB] step up to %0d done at cycle %0d", k % 4, cyc);
    end

    pulse(0, 1, 0, r);
    cmp("down_wrap_vel", {29'b0, velocidad}, 3);
    btn_up = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    btn_up = 1'b0;
    cmp("held_up_vel", {29'b0, velocidad}, 0);
    wait_tick(30, t);
    goto_cyc(t + 5);
    pulse(1, 1, 0, r);
    cmp("conflict_vel", {29'b0, velocidad}, 0);
    tick_gap("conflict_count", t, 21, t);
    $display("[TB] down/hold/conflict done at cycle %0d", cyc);

    goto_cyc(t + 15);
    nt = newtime;
    pulse(1, 0, 0, r);
    cmp("clear_vel", {29'b0, velocidad}, 1);
    cmp("clear_newtime", {31'b0, newtime}, {31'b0, nt});
    tick_gap("clear_first", r, 11, t);
    $display("[TB] count clear done at cycle %0d", cyc);

`ifdef TIME_SCALER_PAUSE_EN
    pulse(0, 1, 0, r);
    wait_tick(30, t);
    goto_cyc(t + 7);
    pulse(0, 0, 1, r);
    cmp("pause_on", {31'b0, paused}, 1);
    nt = newtime;
    count_ticks(30, seen);
    cmp("pause_no_tick", 32'(seen), 0);
    cmp("pause_newtime", {31'b0, newtime}, {31'b0, nt});
    pulse(1, 0, 0, r);
    cmp("pause_up_vel", {29'b0, velocidad}, 1);
    cmp("pause_still", {31'b0, paused}, 1);
    count_ticks(10, seen);
    cmp("pause_up_no_tick", 32'(seen), 0);
    pulse(0, 0, 1, r);
    cmp("pause_off", {31'b0, paused}, 0);
    tick_gap("unpause_first", r, 11, t);
    $display("[TB] pause sequence done at cycle %0d", cyc);
`else
    pulse(0, 0, 1, r);
    cmp("nopause_paused", {31'b0, paused}, 0);
    wait_tick(30, t);
    tick_gap("nopause_period", t, 11, t);
    $display("[TB] pause ignored check done at cycle %0d", cyc);
`endif

    pulse(1, 0, 0, r);
    cmp("pre_rst_vel", {29'b0, velocidad}, 2);
    repeat (3) @(posedge clk);
    #1;
`ifdef TIME_SCALER_PAUSE_EN
    pulse(0, 0, 1, r);
    cmp("pre_rst_paused", {31'b0, paused}, 1);
`endif
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    r = cyc;
    cmp("mid_rst_tick", {31'b0, tick}, 0);
    cmp("mid_rst_newtime", {31'b0, newtime}, 0);
    cmp("mid_rst_vel", {29'b0, velocidad}, 0);
    cmp("mid_rst_paused", {31'b0, paused}, 0);
    tick_gap("mid_rst_first", r, 21, t);
    cmp("mid_rst_newtime1", {31'b0, newtime}, 1);
    $display("[TB] mid-operation reset done at cycle %0d", cyc);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
